requant_pipeline: RTL and testbench

- Per-channel requantization stage that sits directly upstream of the ReLU6 activation stage.
- Takes raw int32 convolution accumulators and applies a per-output-channel bias, a Q31 fixed-point multiplier and a rounding right shift, then adds the output zero point.
- Emits a saturated int32 result plus valid, in a form the ReLU6 stage consumes directly on its conv_result/valid_in inputs.
- Holds a small per-channel parameter table and a channel counter that tracks which output channel each streaming sample belongs to.

---
 rtl/requant_pipeline_if.sv | 39 +++
 rtl/requant_pipeline.sv | 170 +++++++++++++++++
 tb/tb_requant_pipeline.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/requant_pipeline_if.sv
`default_nettype none
// ============================================================================
//  Module      : requant_pipeline_if
//  Description : Streaming, configuration and result signals of the
//                requantization stage. The master side drives samples and
//                table writes; the slave side is the requantizer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface requant_pipeline_if #(
    parameter int MAX_CHANNELS = 64,
    parameter int CH_W         = $clog2(MAX_CHANNELS)
);
    logic signed [31:0] acc_in;
    logic               valid_in;
    logic               frame_start;
    logic [CH_W:0]      num_channels;
    logic signed [31:0] out_zero_point;
    logic               cfg_we;
    logic [CH_W-1:0]    cfg_addr;
    logic signed [31:0] cfg_bias;
    logic signed [31:0] cfg_mult;
    logic [4:0]         cfg_shift;
    logic signed [31:0] requant_out;
    logic [CH_W-1:0]    chan_out;
    logic               valid_out;

    modport master (
        output acc_in, valid_in, frame_start, num_channels, out_zero_point,
        output cfg_we, cfg_addr, cfg_bias, cfg_mult, cfg_shift,
        input  requant_out, chan_out, valid_out
    );

    modport slave (
        input  acc_in, valid_in, frame_start, num_channels, out_zero_point,
        input  cfg_we, cfg_addr, cfg_bias, cfg_mult, cfg_shift,
        output requant_out, chan_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/requant_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : requant_pipeline
//  Description : Per-channel requantization ahead of ReLU6. Applies bias
//                (saturated), Q31 multiply, rounding right shift by 31+shift
//                and output zero point with int32 saturation. Three-cycle
//                latency, one sample per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module requant_pipeline #(
    parameter int MAX_CHANNELS = 64,
    parameter int CH_W         = $clog2(MAX_CHANNELS)
) (
    input  wire logic          clock,
    input  wire logic          reset,
    requant_pipeline_if.slave  bus
);

    localparam logic signed [31:0] c_int_max = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] c_int_min = 32'sh8000_0000;
    localparam logic signed [65:0] c_res_max = 66'sd2147483647;
    localparam logic signed [65:0] c_res_min = -66'sd2147483648;

    // ------------------------------------------------------------------
    // Per-channel parameter table (not reset; contents defined by writes)
    // ------------------------------------------------------------------
    logic signed [31:0] r_bias_tbl  [MAX_CHANNELS];
    logic signed [31:0] r_mult_tbl  [MAX_CHANNELS];
    logic [4:0]         r_shift_tbl [MAX_CHANNELS];

    // Channel tracking
    logic [CH_W-1:0]    r_chan_cnt;
    logic [CH_W-1:0]    w_sample_ch;
    logic [CH_W:0]      w_next_ch;

    // Stage 0: captured sample and its parameters
    logic               r0_valid;
    logic signed [31:0] r0_acc;
    logic signed [31:0] r0_bias;
    logic signed [31:0] r0_mult;
    logic [4:0]         r0_shift;
    logic [CH_W-1:0]    r0_chan;

    // Bias add + multiply (combinational between stage 0 and stage 1)
    logic signed [32:0] w_sum;
    logic signed [31:0] w_sum_sat;
    logic signed [63:0] w_sum_ext;
    logic signed [63:0] w_mult_ext;
    logic signed [63:0] w_prod;

    // Stage 1: product
    logic               r1_valid;
    logic signed [63:0] r1_prod;
    logic [4:0]         r1_shift;
    logic [CH_W-1:0]    r1_chan;

    // Rounding shift, zero point and saturation
    logic [5:0]         w_total;
    logic signed [64:0] w_prod_ext;
    logic signed [64:0] w_half;
    logic signed [64:0] w_rnd;
    logic signed [65:0] w_res;
    logic signed [31:0] w_res_sat;

    // Output stage
    logic               r_valid_out;
    logic signed [31:0] r_requant_out;
    logic [CH_W-1:0]    r_chan_out;

    // A frame start forces the current sample onto channel 0
    assign w_sample_ch = bus.frame_start ? '0 : r_chan_cnt;
    assign w_next_ch   = {1'b0, w_sample_ch} + {{CH_W{1'b0}}, 1'b1};

    // Table writes; a read in the same cycle sees the old entry
    always_ff @(posedge clock) begin
        if (bus.cfg_we) begin
            r_bias_tbl[bus.cfg_addr]  <= bus.cfg_bias;
            r_mult_tbl[bus.cfg_addr]  <= bus.cfg_mult;
            r_shift_tbl[bus.cfg_addr] <= bus.cfg_shift;
        end
    end

    // Channel counter: advance per sample, wrap at num_channels
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chan_cnt <= '0;
        end else if (bus.valid_in) begin
            r_chan_cnt <= (w_next_ch >= bus.num_channels) ? '0 : w_next_ch[CH_W-1:0];
        end else if (bus.frame_start) begin
            r_chan_cnt <= '0;
        end
    end

    // Stage valid pipeline, cleared by reset so in-flight samples vanish
    always_ff @(posedge clock) begin
        if (reset) begin
            r0_valid    <= 1'b0;
            r1_valid    <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r0_valid    <= bus.valid_in;
            r1_valid    <= r0_valid;
            r_valid_out <= r1_valid;
        end
    end

    // Stage 0 data: register the sample with its table entry
    always_ff @(posedge clock) begin
        if (bus.valid_in) begin
            r0_acc   <= bus.acc_in;
            r0_bias  <= r_bias_tbl[w_sample_ch];
            r0_mult  <= r_mult_tbl[w_sample_ch];
            r0_shift <= r_shift_tbl[w_sample_ch];
            r0_chan  <= w_sample_ch;
        end
    end

    // Bias add in 33 bits, clamp to int32, then full 64-bit product
    always_comb begin
        w_sum     = {r0_acc[31], r0_acc} + {r0_bias[31], r0_bias};
        w_sum_sat = w_sum[31:0];
        if (w_sum[32] != w_sum[31]) begin
            w_sum_sat = w_sum[32] ? c_int_min : c_int_max;
        end
        w_sum_ext  = {{32{w_sum_sat[31]}}, w_sum_sat};
        w_mult_ext = {{32{r0_mult[31]}}, r0_mult};
        w_prod     = w_sum_ext * w_mult_ext;
    end

    // Stage 1 data: register the product
    always_ff @(posedge clock) begin
        if (r0_valid) begin
            r1_prod  <= w_prod;
            r1_shift <= r0_shift;
            r1_chan  <= r0_chan;
        end
    end

    // Round half up, shift by 31+shift, add zero point, clamp to int32
    always_comb begin
        w_total    = 6'd31 + {1'b0, r1_shift};
        w_prod_ext = {r1_prod[63], r1_prod};
        w_half     = 65'sd1 <<< (w_total - 6'd1);
        w_rnd      = (w_prod_ext + w_half) >>> w_total;
        w_res      = {w_rnd[64], w_rnd} + {{34{bus.out_zero_point[31]}}, bus.out_zero_point};
        w_res_sat  = w_res[31:0];
        if (w_res > c_res_max) begin
            w_res_sat = c_int_max;
        end else if (w_res < c_res_min) begin
            w_res_sat = c_int_min;
        end
    end

    // Output register: holds its last value between valid samples
    always_ff @(posedge clock) begin
        if (reset) begin
            r_requant_out <= '0;
            r_chan_out    <= '0;
        end else if (r1_valid) begin
            r_requant_out <= w_res_sat;
            r_chan_out    <= r1_chan;
        end
    end

    assign bus.requant_out = r_requant_out;
    assign bus.chan_out    = r_chan_out;
    assign bus.valid_out   = r_valid_out;

endmodule
`default_nettype wire

// File: tb/tb_requant_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_requant_pipeline
//  Description : Directed, table-driven bench for requant_pipeline with
//                hand-written sequences for channel wrap, frame start,
//                config hazard and mid-stream reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_requant_pipeline;

    localparam int c_max_ch = 64;
    localparam int c_nvec   = 12;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    requant_pipeline_if #(.MAX_CHANNELS(c_max_ch)) bus ();

    requant_pipeline #(.MAX_CHANNELS(c_max_ch)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic signed [31:0] acc;
        logic signed [31:0] bias;
        logic signed [31:0] mult;
        logic [4:0]         shift;
        logic signed [31:0] zp;
        logic signed [31:0] exp;
    } vec_t;

    vec_t vecs [c_nvec];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] bias,
                             input logic [31:0] mult, input logic [4:0] shift);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 6'(addr);
        bus.cfg_bias  = bias;
        bus.cfg_mult  = mult;
        bus.cfg_shift = shift;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    initial begin
        // acc, bias, mult, shift, zp, expected
        vecs[0]  = '{32'sd1000, 32'sd24, 32'sh4000_0000, 5'd0, 32'sd0, 32'sd512};
        vecs[1]  = '{32'sd3, 32'sd0, 32'sh4000_0000, 5'd0, 32'sd0, 32'sd2};
        vecs[2]  = '{-32'sd3, 32'sd0, 32'sh4000_0000, 5'd0, 32'sd0, -32'sd1};
        vecs[3]  = '{32'sd1, 32'sd0, 32'sh4000_0000, 5'd0, 32'sd0, 32'sd1};
        vecs[4]  = '{-32'sd1, 32'sd0, 32'sh4000_0000, 5'd0, 32'sd0, 32'sd0};
        vecs[5]  = '{32'sh7FFF_FFFF, 32'sd1, 32'sh7FFF_FFFF, 5'd0, 32'sd10, 32'sh7FFF_FFFF};
        vecs[6]  = '{32'sh8000_0000, -32'sd1, 32'sh4000_0000, 5'd0, 32'sd0, 32'shC000_0000};
        vecs[7]  = '{32'sd1000, 32'sd0, 32'sh7FFF_FFFF, 5'd3, 32'sd0, 32'sd125};
        vecs[8]  = '{32'sh7FFF_FFFF, 32'sd0, 32'sh7FFF_FFFF, 5'd31, 32'sd0, 32'sd1};
        vecs[9]  = '{32'sh8000_0000, 32'sd0, 32'sh7FFF_FFFF, 5'd0, -32'sd100, 32'sh8000_0000};
        vecs[10] = '{32'sd200, -32'sd100, 32'sh4000_0000, 5'd0, 32'sd7, 32'sd57};
        vecs[11] = '{32'sd10, 32'sd0, 32'shC000_0000, 5'd0, 32'sd0, -32'sd5};

        reset              = 1'b1;
        bus.acc_in         = '0;
        bus.valid_in       = 1'b0;
        bus.frame_start    = 1'b0;
        bus.num_channels   = 7'd1;
        bus.out_zero_point = '0;
        bus.cfg_we         = 1'b0;
        bus.cfg_addr       = '0;
        bus.cfg_bias       = '0;
        bus.cfg_mult       = '0;
        bus.cfg_shift      = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_valid_out", 32'(bus.valid_out), 32'd0);
        check("reset_requant_out", bus.requant_out, 32'd0);
        check("reset_chan_out", 32'(bus.chan_out), 32'd0);

        // Single-channel vectors, each applied in isolation to check latency
        for (int i = 0; i < c_nvec; i++) begin
            cfg_write(0, vecs[i].bias, vecs[i].mult, vecs[i].shift);
            bus.out_zero_point = vecs[i].zp;
            bus.acc_in         = vecs[i].acc;
            bus.valid_in       = 1'b1;
            tick();
            bus.valid_in = 1'b0;
            check("vec_lat1_valid", 32'(bus.valid_out), 32'd0);
            tick();
            check("vec_lat2_valid", 32'(bus.valid_out), 32'd0);
            tick();
            check("vec_valid", 32'(bus.valid_out), 32'd1);
            check($sformatf("vec%0d_result", i), bus.requant_out, vecs[i].exp);
            check("vec_chan", 32'(bus.chan_out), 32'd0);
            tick();
            check("vec_hold_valid", 32'(bus.valid_out), 32'd0);
            check("vec_hold_result", bus.requant_out, vecs[i].exp);
        end
        bus.out_zero_point = '0;

        // Channel wrap: three channels with distinct multipliers
        bus.num_channels = 7'd3;
        cfg_write(0, 32'sd0, 32'sh4000_0000, 5'd0);
        cfg_write(1, 32'sd0, 32'sh2000_0000, 5'd0);
        cfg_write(2, 32'sd0, 32'sh1000_0000, 5'd0);
        begin
            int exp_ch [6]  = '{0, 1, 2, 0, 1, 2};
            int exp_val [3] = '{400, 200, 100};
            for (int i = 0; i < 8; i++) begin
                bus.valid_in = (i < 6);
                bus.acc_in   = 32'sd800;
                tick();
                if (i >= 2) begin
                    check("wrap_valid", 32'(bus.valid_out), 32'd1);
                    check("wrap_chan", 32'(bus.chan_out), 32'(exp_ch[i-2]));
                    check("wrap_result", bus.requant_out, 32'(exp_val[exp_ch[i-2]]));
                end
            end
            bus.valid_in = 1'b0;
            tick();
            check("wrap_tail_valid", 32'(bus.valid_out), 32'd0);
        end

        // Frame start with the third sample restarts at channel 0
        begin
            int exp_ch [5]  = '{0, 1, 0, 1, 2};
            int exp_val [3] = '{400, 200, 100};
            for (int i = 0; i < 7; i++) begin
                bus.valid_in    = (i < 5);
                bus.frame_start = (i == 2);
                bus.acc_in      = 32'sd800;
                tick();
                if (i >= 2) begin
                    check("fs_valid", 32'(bus.valid_out), 32'd1);
                    check("fs_chan", 32'(bus.chan_out), 32'(exp_ch[i-2]));
                    check("fs_result", bus.requant_out, 32'(exp_val[exp_ch[i-2]]));
                end
            end
            bus.valid_in    = 1'b0;
            bus.frame_start = 1'b0;
        end

        // Config hazard: write to ch0 coinciding with a ch0 sample
        bus.num_channels = 7'd1;
        cfg_write(0, 32'sd0, 32'sh4000_0000, 5'd0);
        bus.valid_in  = 1'b1;
        bus.acc_in    = 32'sd100;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = '0;
        bus.cfg_bias  = 32'sd100;
        bus.cfg_mult  = 32'sh4000_0000;
        bus.cfg_shift = 5'd0;
        tick();
        bus.cfg_we = 1'b0;
        tick();
        bus.valid_in = 1'b0;
        tick();
        check("hazard_old_valid", 32'(bus.valid_out), 32'd1);
        check("hazard_old_bias", bus.requant_out, 32'sd50);
        tick();
        check("hazard_new_valid", 32'(bus.valid_out), 32'd1);
        check("hazard_new_bias", bus.requant_out, 32'sd100);

        // Reset with two samples in flight
        bus.num_channels = 7'd3;
        bus.frame_start  = 1'b1;
        bus.valid_in     = 1'b1;
        bus.acc_in       = 32'sd100;
        tick();
        bus.frame_start = 1'b0;
        tick();
        bus.valid_in = 1'b0;
        reset        = 1'b1;
        tick();
        check("rst_drop0_valid", 32'(bus.valid_out), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_drop_valid", 32'(bus.valid_out), 32'd0);
        end
        bus.valid_in = 1'b1;
        bus.acc_in   = 32'sd100;
        tick();
        bus.valid_in = 1'b0;
        tick();
        tick();
        check("rst_after_valid", 32'(bus.valid_out), 32'd1);
        check("rst_after_chan", 32'(bus.chan_out), 32'd0);
        check("rst_after_result", bus.requant_out, 32'sd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
